// File: rtl/corescore_pkg.sv
// Shared definitions for the corescore stream schedulers: FSM encoding and
// default widths.
package corescore_pkg;

   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_LOCK = 1'b1;

   localparam int DATA_W_DEF = 8;

   // Pointer width that stays legal for a single-port configuration.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/corescore_rr_pick.sv
// Rotating priority encoder: one-hot grant of the first request at or after
// ptr, searching upward with wrap. ptr must be below NUM_PORTS.
module corescore_rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int PTR_W     = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PTR_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] gnt,
   output logic                 any
);

   logic [2*NUM_PORTS-1:0] req_dbl;
   logic [2*NUM_PORTS-1:0] gnt_dbl;
   logic [NUM_PORTS-1:0]   rot_req;
   logic [NUM_PORTS-1:0]   rot_gnt;

   // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
   assign req_dbl = {req, req} >> ptr;
   assign rot_req = req_dbl[NUM_PORTS-1:0];
   assign rot_gnt = rot_req & (~rot_req + NUM_PORTS'(1));
   assign gnt_dbl = {rot_gnt, rot_gnt} << ptr;
   assign gnt     = gnt_dbl[2*NUM_PORTS-1:NUM_PORTS];
   assign any     = |req;

endmodule

// File: rtl/corescore_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding the UART emitter stream; a grant
// is held until the granted source's tlast beat is accepted.
module corescore_pkt_arbiter
   import corescore_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = DATA_W_DEF
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [NUM_PORTS*DATA_W-1:0] i_tdata,
   input  logic [NUM_PORTS-1:0]        i_tlast,
   input  logic [NUM_PORTS-1:0]        i_tvalid,
   output logic [NUM_PORTS-1:0]        o_tready,
   output logic [DATA_W-1:0]           o_tdata,
   output logic                        o_tlast,
   output logic                        o_tvalid,
   input  logic                        i_tready,
   output logic [NUM_PORTS-1:0]        o_grant,
   output logic                        o_busy
);

   localparam int PTR_W = ptr_width(NUM_PORTS);

   logic                 state;
   logic [PTR_W-1:0]     ptr;
   logic [NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0] pick_gnt;
   logic                 pick_any;
   logic                 out_free;
   logic                 accept;
   logic [DATA_W-1:0]    sel_data;
   logic                 sel_last;
   logic [PTR_W-1:0]     g_idx;
   logic [PTR_W-1:0]     ptr_next;

   corescore_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
   ) u_pick (
      .req (i_tvalid),
      .ptr (ptr),
      .gnt (pick_gnt),
      .any (pick_any)
   );

   // The output slot can take a beat when empty or draining this cycle.
   assign out_free = !o_tvalid || i_tready;
   assign o_tready = (state == STATE_LOCK && out_free) ? grant : '0;
   assign accept   = |(i_tvalid & o_tready);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      g_idx    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (grant[k]) begin
            sel_data = i_tdata[k*DATA_W +: DATA_W];
            sel_last = i_tlast[k];
            g_idx    = PTR_W'(k);
         end
      end
   end

   assign ptr_next = (g_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : g_idx + PTR_W'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= STATE_IDLE;
         ptr   <= '0;
         grant <= '0;
      end else begin
         case (state)
            STATE_IDLE: begin
               if (pick_any) begin
                  grant <= pick_gnt;
                  state <= STATE_LOCK;
               end
            end
            default: begin
               if (accept && sel_last) begin
                  grant <= '0;
                  ptr   <= ptr_next;
                  state <= STATE_IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_tdata  <= '0;
         o_tlast  <= 1'b0;
         o_tvalid <= 1'b0;
      end else if (accept) begin
         o_tdata  <= sel_data;
         o_tlast  <= sel_last;
         o_tvalid <= 1'b1;
      end else if (i_tready) begin
         o_tvalid <= 1'b0;
      end
   end

   assign o_grant = grant;
   assign o_busy  = (state == STATE_LOCK);

endmodule

// File: tb/tb_corescore_pkt_arbiter.sv
// Scoreboard bench for corescore_pkt_arbiter: drivers push expected beats and
// grants, a negedge monitor pops and compares on every output transfer.
module tb_corescore_pkt_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;

   logic             clk;
   logic             i_rst;
   logic [NP*DW-1:0] i_tdata;
   logic [NP-1:0]    tlast_v;
   logic [NP-1:0]    tvalid_v;
   logic [NP-1:0]    o_tready;
   logic [DW-1:0]    o_tdata;
   logic             o_tlast;
   logic             o_tvalid;
   logic             i_tready;
   logic [NP-1:0]    o_grant;
   logic             o_busy;

   logic [DW-1:0] tdata_a [NP];

   int       checks;
   int       errors;
   bit       mon_en;
   logic [8:0] beat_q [$];
   logic [3:0] grant_q [$];

   corescore_pkt_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
      .i_clk    (clk),
      .i_rst    (i_rst),
      .i_tdata  (i_tdata),
      .i_tlast  (tlast_v),
      .i_tvalid (tvalid_v),
      .o_tready (o_tready),
      .o_tdata  (o_tdata),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .i_tready (i_tready),
      .o_grant  (o_grant),
      .o_busy   (o_busy)
   );

   always_comb begin
      i_tdata = '0;
      for (int k = 0; k < NP; k++) i_tdata[k*DW +: DW] = tdata_a[k];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic monitor();
      logic [3:0] prev;
      logic [8:0] eb;
      logic [3:0] eg;
      prev = '0;
      forever begin
         @(negedge clk);
         if (mon_en && o_tvalid && i_tready) begin
            if (beat_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL out_beat actual=%h required=none", {o_tlast, o_tdata});
            end else begin
               eb = beat_q.pop_front();
               check("out_beat", {23'd0, o_tlast, o_tdata}, {23'd0, eb});
            end
         end
         if (mon_en && prev == '0 && o_grant != '0) begin
            if (grant_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL grant_order actual=%b required=none", o_grant);
            end else begin
               eg = grant_q.pop_front();
               check("grant_order", {28'd0, o_grant}, {28'd0, eg});
            end
         end
         prev = o_grant;
      end
   endtask

   // Call at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send_beat(input int p, input logic [7:0] d, input logic l);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      tdata_a[p]  = d;
      tlast_v[p]  = l;
      tvalid_v[p] = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         if (o_tready[p]) done = 1;
         n++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout port=%0d actual=no_accept required=accept", p);
      end
      @(posedge clk); #1;
      tvalid_v[p] = 1'b0;
      tlast_v[p]  = 1'b0;
   endtask

   task automatic do_reset();
      tvalid_v = '0;
      tlast_v  = '0;
      i_tready = 1'b1;
      i_rst    = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (4) @(posedge clk);
      #1;
      check({name, "_beats_left"}, beat_q.size(), 0);
      check({name, "_grants_left"}, grant_q.size(), 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mon_en = 1'b1;
      for (int k = 0; k < NP; k++) tdata_a[k] = '0;
      tvalid_v = '0;
      tlast_v  = '0;
      i_tready = 1'b1;
      i_rst    = 1'b1;
      fork
         monitor();
      join_none
      #12;
      i_rst = 1'b0;
      @(posedge clk); #1;

      // 1: idle after reset
      @(negedge clk);
      check("rst_tdata", o_tdata, 0);
      check("rst_tlast", o_tlast, 0);
      check("rst_tready", o_tready, 0);
      for (int c = 0; c < 20; c++) begin
         check("idle_state", {o_grant, o_tvalid, o_busy}, 0);
         @(negedge clk);
      end

      // 2: port 2 three-byte message
      do_reset();
      beat_q.push_back(9'h048); beat_q.push_back(9'h069); beat_q.push_back(9'h10A);
      grant_q.push_back(4'b0100);
      fork
         begin
            send_beat(2, 8'h48, 1'b0);
            send_beat(2, 8'h69, 1'b0);
            send_beat(2, 8'h0A, 1'b1);
         end
         begin
            @(posedge clk); @(negedge clk);
            check("t2_grant", o_grant, 4'b0100);
            check("t2_busy", o_busy, 1);
         end
      join
      check("t2_release_grant", o_grant, 0);
      check("t2_release_busy", o_busy, 0);
      drain("t2");

      // 3: all ports request, strict rotation with wrap back to 0
      do_reset();
      beat_q.push_back(9'h010); beat_q.push_back(9'h111);
      beat_q.push_back(9'h020); beat_q.push_back(9'h121);
      beat_q.push_back(9'h030); beat_q.push_back(9'h131);
      beat_q.push_back(9'h040); beat_q.push_back(9'h141);
      beat_q.push_back(9'h012); beat_q.push_back(9'h113);
      grant_q.push_back(4'b0001); grant_q.push_back(4'b0010);
      grant_q.push_back(4'b0100); grant_q.push_back(4'b1000);
      grant_q.push_back(4'b0001);
      fork
         begin
            send_beat(0, 8'h10, 1'b0); send_beat(0, 8'h11, 1'b1);
            send_beat(0, 8'h12, 1'b0); send_beat(0, 8'h13, 1'b1);
         end
         begin send_beat(1, 8'h20, 1'b0); send_beat(1, 8'h21, 1'b1); end
         begin send_beat(2, 8'h30, 1'b0); send_beat(2, 8'h31, 1'b1); end
         begin send_beat(3, 8'h40, 1'b0); send_beat(3, 8'h41, 1'b1); end
      join
      drain("t3");

      // 4: emitter backpressure during port 1 packet
      do_reset();
      beat_q.push_back(9'h0A1); beat_q.push_back(9'h0A2); beat_q.push_back(9'h1A3);
      grant_q.push_back(4'b0010);
      fork
         begin
            send_beat(1, 8'hA1, 1'b0);
            send_beat(1, 8'hA2, 1'b0);
            send_beat(1, 8'hA3, 1'b1);
         end
         begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!o_tvalid && n < 50);
            check("t4_first_valid", o_tvalid, 1);
            @(posedge clk); #1; i_tready = 1'b0;
            for (int s = 0; s < 2; s++) begin
               @(negedge clk);
               check("t4_stall_data", {o_tvalid, o_tlast, o_tdata}, {2'b10, 8'hA2});
               check("t4_stall_tready", o_tready[1], 0);
               @(posedge clk); #1;
            end
            i_tready = 1'b1;
         end
      join
      drain("t4");

      // 5: granted port stalls mid-packet, port 3 starves
      do_reset();
      beat_q.push_back(9'h050); beat_q.push_back(9'h151); beat_q.push_back(9'h160);
      grant_q.push_back(4'b0001); grant_q.push_back(4'b1000);
      fork
         begin
            send_beat(0, 8'h50, 1'b0);
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               check("t5_hold_grant", o_grant, 4'b0001);
               check("t5_starve_p3", o_tready[3], 0);
            end
            @(posedge clk); #1;
            send_beat(0, 8'h51, 1'b1);
         end
         send_beat(3, 8'h60, 1'b1);
      join
      drain("t5");

      // 6: async reset mid-packet; pointer restarts at 0
      do_reset();
      beat_q.push_back(9'h170);
      grant_q.push_back(4'b0100);
      send_beat(2, 8'h70, 1'b1);
      drain("t6_pre");
      mon_en = 1'b0;
      tdata_a[2] = 8'h71; tlast_v[2] = 1'b0; tvalid_v[2] = 1'b1;
      @(posedge clk); @(posedge clk);
      #3;
      i_rst = 1'b1;
      #1;
      check("t6_async_outs", {o_grant, o_busy, o_tvalid, o_tlast}, 0);
      check("t6_async_data", o_tdata, 0);
      check("t6_async_tready", o_tready, 0);
      tvalid_v = '0;
      @(posedge clk); #1;
      i_rst = 1'b0;
      mon_en = 1'b1;
      beat_q.push_back(9'h181); beat_q.push_back(9'h183);
      grant_q.push_back(4'b0010); grant_q.push_back(4'b1000);
      fork
         send_beat(1, 8'h81, 1'b1);
         send_beat(3, 8'h83, 1'b1);
      join
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
